uart_time_rx: RTL and testbench

- Parametrised UART receiver and time-frame parser. It is the successor of the current top-level UART time input.
- Receives 8N1 serial bytes on i_Rx_Serial and assembles a 4-byte frame: header, hours, minutes, checksum.
- Validates the frame, then presents hours/minutes with a one-cycle load strobe to the clock/display logic.
- Adds what the current block lacks: compile-time baud parameter, input synchroniser, start-glitch rejection, framing/checksum/range checking, inter-byte timeout, and an error strobe with a cause code.

---
 rtl/uart_time_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_time_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_rx.sv
// uart_time_rx: 8N1 UART receiver plus time-frame parser.
// Receives four-byte frames {HDR_BYTE, hours, minutes, hours^minutes}, checks
// framing, checksum, range and inter-byte timeout, then loads hours/minutes
// with a one-cycle strobe or reports the rejection cause.
//
// Ports:
//   i_Clock      system clock, rising edge
//   reset        asynchronous active-low reset
//   i_Rx_Serial  UART line (idles high, asynchronous)
//   ore          last accepted hours
//   minute       last accepted minutes
//   load         one-cycle strobe when ore/minute update
//   err          one-cycle strobe when a frame is rejected
//   err_code     last rejection cause: 1 framing, 2 checksum, 3 range/timeout
//
// Bit FSM:
//   state   | meaning
//   S_IDLE  | line idle, waiting for falling edge
//   S_START | timing to middle of start bit, glitch check
//   S_DATA  | sampling 8 data bits LSB first
//   S_STOP  | sampling stop bit
// Parser FSM:
//   state   | meaning
//   P_HDR   | hunting for header byte
//   P_HR    | expecting hours byte
//   P_MIN   | expecting minutes byte
//   P_CHK   | expecting checksum byte
module uart_time_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5,
  parameter int          HR_W         = 6,
  parameter int          MIN_W        = 7,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic             i_Clock,
  input  logic             reset,
  input  logic             i_Rx_Serial,
  output logic [HR_W-1:0]  ore,
  output logic [MIN_W-1:0] minute,
  output logic             load,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam int             TO_CYC    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int             TO_W      = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_e;
  typedef enum logic [1:0] {P_HDR, P_HR, P_MIN, P_CHK} prs_state_e;

  logic [1:0]  sync_q;
  logic        rx_s, rx_prev_q, start_det;
  bit_state_e  bit_st_q, bit_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;

  prs_state_e  prs_q, prs_d;
  logic [7:0]  hr_tmp_q, hr_tmp_d, min_tmp_q, min_tmp_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic        counting, timeout;
  logic [HR_W-1:0]  ore_q, ore_d;
  logic [MIN_W-1:0] minute_q, minute_d;
  logic        load_q, load_d, err_q, err_d;
  logic [1:0]  code_q, code_d;

  assign rx_s      = sync_q[1];
  assign start_det = (bit_st_q == S_IDLE) && rx_prev_q && !rx_s;

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      bit_st_q     <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_Rx_Serial};
      rx_prev_q    <= rx_s;
      bit_st_q     <= bit_st_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Down-counter reaches zero at each sample point: mid start bit first,
  // then one full bit period per data/stop bit.
  always_comb begin
    bit_st_d     = bit_st_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (bit_st_q)
      S_IDLE: begin
        if (start_det) begin
          bit_st_d = S_START;
          cnt_d    = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s) bit_st_d = S_IDLE;
          else begin
            bit_st_d  = S_DATA;
            cnt_d     = BIT_LOAD;
            bit_idx_d = '0;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            bit_st_d  = S_STOP;
            bit_idx_d = '0;
          end else bit_idx_d = bit_idx_q + 3'd1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_STOP: begin
        // Leave for IDLE at mid stop bit so an early next start edge is caught.
        if (cnt_q == '0) begin
          bit_st_d = S_IDLE;
          if (rx_s) byte_valid_d = 1'b1;
          else      frame_err_d  = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      default: bit_st_d = S_IDLE;
    endcase
  end

  // Inter-byte idle timer only runs mid-frame while the line is idle.
  assign counting = (prs_q != P_HDR) && (bit_st_q == S_IDLE) && !start_det;
  assign timeout  = counting && (to_cnt_q == '0) && !byte_valid_q && !frame_err_q;

  always_comb begin
    prs_d     = prs_q;
    hr_tmp_d  = hr_tmp_q;
    min_tmp_d = min_tmp_q;
    ore_d     = ore_q;
    minute_d  = minute_q;
    load_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    to_cnt_d  = to_cnt_q;

    if (start_det || prs_q == P_HDR || byte_valid_q) to_cnt_d = TO_LOAD;
    else if (counting && to_cnt_q != '0)            to_cnt_d = to_cnt_q - TO_W'(1);

    if (frame_err_q) begin
      err_d  = 1'b1;
      code_d = 2'd1;
      prs_d  = P_HDR;
    end else if (byte_valid_q) begin
      case (prs_q)
        P_HDR: if (shift_q == HDR_BYTE) prs_d = P_HR;
        P_HR: begin
          hr_tmp_d = shift_q;
          prs_d    = P_MIN;
        end
        P_MIN: begin
          min_tmp_d = shift_q;
          prs_d     = P_CHK;
        end
        P_CHK: begin
          prs_d = P_HDR;
          if (shift_q != (hr_tmp_q ^ min_tmp_q)) begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end else if (hr_tmp_q > 8'd23 || min_tmp_q > 8'd59) begin
            err_d  = 1'b1;
            code_d = 2'd3;
          end else begin
            ore_d    = hr_tmp_q[HR_W-1:0];
            minute_d = min_tmp_q[MIN_W-1:0];
            load_d   = 1'b1;
          end
        end
        default: prs_d = P_HDR;
      endcase
    end else if (timeout) begin
      err_d  = 1'b1;
      code_d = 2'd3;
      prs_d  = P_HDR;
    end
  end

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      prs_q     <= P_HDR;
      hr_tmp_q  <= '0;
      min_tmp_q <= '0;
      to_cnt_q  <= TO_LOAD;
      ore_q     <= '0;
      minute_q  <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      prs_q     <= prs_d;
      hr_tmp_q  <= hr_tmp_d;
      min_tmp_q <= min_tmp_d;
      to_cnt_q  <= to_cnt_d;
      ore_q     <= ore_d;
      minute_q  <= minute_d;
      load_q    <= load_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign ore      = ore_q;
  assign minute   = minute_q;
  assign load     = load_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_uart_time_rx.sv
// Bench for uart_time_rx: byte-level frame model feeds an expected-event
// queue; a per-cycle compare process checks strobes and held outputs.
module tb_uart_time_rx;
  localparam int CPB     = 16;
  localparam int TO_BITS = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [5:0] ore;
  logic [6:0] minute;
  logic       load, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_time_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk), .reset(rst_n), .i_Rx_Serial(rx),
    .ore(ore), .minute(minute), .load(load), .err(err), .err_code(err_code)
  );

  typedef struct {
    bit         is_load;
    logic [1:0] code;
    logic [7:0] h;
    logic [7:0] m;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_e;
  int         errors = 0;
  int         checks = 0;
  int         n_load = 0;
  int         n_err  = 0;
  bit         chk_en = 1'b0;
  int         st = 0;
  logic [7:0] mh = '0, mm = '0;
  logic [5:0] m_ore  = '0;
  logic [6:0] m_min  = '0;
  logic [1:0] m_code = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic void push_ev(input bit is_load, input logic [1:0] code,
                                  input logic [7:0] h, input logic [7:0] m);
    ev_t e;
    e.is_load = is_load; e.code = code; e.h = h; e.m = m;
    exp_q.push_back(e);
  endfunction

  // Frame rules applied to whole bytes.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      push_ev(1'b0, 2'd1, 8'h0, 8'h0);
      st = 0;
    end else begin
      case (st)
        0: if (b == 8'hA5) st = 1;
        1: begin mh = b; st = 2; end
        2: begin mm = b; st = 3; end
        default: begin
          if (b != (mh ^ mm))           push_ev(1'b0, 2'd2, 8'h0, 8'h0);
          else if (mh > 23 || mm > 59)  push_ev(1'b0, 2'd3, 8'h0, 8'h0);
          else                          push_ev(1'b1, 2'd0, mh, mm);
          st = 0;
        end
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (load || err) begin
        check("strobe_overlap", 32'(load & err), 32'd0);
        if (load) n_load++;
        if (err)  n_err++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({load, err}), 32'd0);
        end else begin
          cur_e = exp_q.pop_front();
          check("strobe_kind", 32'(load), 32'(cur_e.is_load));
          if (cur_e.is_load) begin
            m_ore = cur_e.h[5:0];
            m_min = cur_e.m[6:0];
          end else m_code = cur_e.code;
        end
      end
      check("ore", 32'(ore), 32'(m_ore));
      check("minute", 32'(minute), 32'(m_min));
      check("err_code", 32'(err_code), 32'(m_code));
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx = 1'b1;
    if (!stop_ok) drive_bit(1'b1);
  endtask

  task automatic idle_bits(input int n);
    if (st != 0 && n >= TO_BITS) begin
      push_ev(1'b0, 2'd3, 8'h0, 8'h0);
      st = 0;
    end
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_byte(a, 1'b1); send_byte(b, 1'b1);
    send_byte(c, 1'b1); send_byte(d, 1'b1);
    idle_bits(2);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int sl, se;
    logic [7:0] h, m, c, junk;
    logic [7:0] bytes [4];
    int kind, fe_pos;

    rst_n = 1'b1;
    rx    = 1'b1;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ore", 32'(ore), 32'd0);
    check("rst_minute", 32'(minute), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    #2 rst_n = 1'b1;
    idle_bits(2);

    sl = n_load; se = n_err;
    send_frame(8'hA5, 8'h0C, 8'h1E, 8'h12);
    check("f1_ore", 32'(ore), 32'd12);
    check("f1_minute", 32'(minute), 32'd30);
    check("f1_loads", 32'(n_load - sl), 32'd1);
    check("f1_errs", 32'(n_err - se), 32'd0);

    sl = n_load; se = n_err;
    send_frame(8'hA5, 8'h0C, 8'h1E, 8'h13);
    check("f2_code", 32'(err_code), 32'd2);
    check("f2_ore", 32'(ore), 32'd12);
    check("f2_loads", 32'(n_load - sl), 32'd0);
    check("f2_errs", 32'(n_err - se), 32'd1);

    send_frame(8'hA5, 8'h18, 8'h05, 8'h1D);
    check("f3_code", 32'(err_code), 32'd3);
    check("f3_minute", 32'(minute), 32'd30);
    send_frame(8'hA5, 8'h17, 8'h3B, 8'h2C);
    check("f4_ore", 32'(ore), 32'd23);
    check("f4_minute", 32'(minute), 32'd59);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h0C, 1'b0);
    idle_bits(1);
    check("fe_code", 32'(err_code), 32'd1);
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
    check("f5_ore", 32'(ore), 32'd1);
    check("f5_minute", 32'(minute), 32'd2);

    sl = n_load; se = n_err;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_loads", 32'(n_load - sl), 32'd0);
    check("glitch_errs", 32'(n_err - se), 32'd0);
    send_frame(8'hA5, 8'h02, 8'h03, 8'h01);
    check("post_glitch_ore", 32'(ore), 32'd2);

    send_byte(8'hA5, 1'b1); send_byte(8'h0C, 1'b1);
    idle_bits(19);
    send_byte(8'h1E, 1'b1); send_byte(8'h12, 1'b1);
    idle_bits(2);
    check("near_to_ore", 32'(ore), 32'd12);
    check("near_to_minute", 32'(minute), 32'd30);

    se = n_err;
    send_byte(8'hA5, 1'b1); send_byte(8'h0C, 1'b1);
    idle_bits(21);
    check("to_code", 32'(err_code), 32'd3);
    check("to_errs", 32'(n_err - se), 32'd1);

    send_byte(8'hA5, 1'b1); send_byte(8'h0C, 1'b1);
    #2;
    st = 0; m_ore = '0; m_min = '0; m_code = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_ore", 32'(ore), 32'd0);
    check("mid_rst_minute", 32'(minute), 32'd0);
    check("mid_rst_code", 32'(err_code), 32'd0);
    #2 rst_n = 1'b1;
    sl = n_load;
    send_byte(8'h1E, 1'b1); send_byte(8'h12, 1'b1);
    idle_bits(2);
    check("after_rst_loads", 32'(n_load - sl), 32'd0);
    check("after_rst_ore", 32'(ore), 32'd0);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 5);
      h = 8'($urandom_range(0, 23));
      m = 8'($urandom_range(0, 59));
      if (kind == 4) begin
        if ($urandom_range(0, 1) == 1) h = 8'($urandom_range(24, 255));
        else                           m = 8'($urandom_range(60, 255));
      end
      c = h ^ m;
      if (kind == 3) c = c ^ 8'($urandom_range(1, 255));
      fe_pos = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'hA4;
        send_byte(junk, 1'b1);
        idle_bits($urandom_range(0, 3));
      end
      bytes[0] = 8'hA5; bytes[1] = h; bytes[2] = m; bytes[3] = c;
      for (int i = 0; i < 4; i++) begin
        send_byte(bytes[i], !(kind == 5 && i == fe_pos));
        idle_bits($urandom_range(0, 3));
      end
    end
    idle_bits(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
